// File: rtl/mc_mem_pkg.sv
// Shared definitions for the multicycle CPU data memory.
//   SZ_*        : request size encodings (2'b11 is illegal)
//   state_e     : controller FSM states
//   access_err  : flags illegal size, misalignment or an address beyond the memory depth
package mc_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Accesses are naturally aligned, so checking the first byte's upper address bits
  // is enough to keep every byte of the access inside the array.
  function automatic logic access_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input int unsigned addr_w);
    logic        err;
    logic [31:0] hi;
    hi = (addr_w >= 32) ? 32'd0 : (addr >> addr_w);
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr[0];
      SZ_WORD: err = |addr[1:0];
      default: err = 1'b1;
    endcase
    if (hi != 32'd0) begin
      err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/mc_load_align.sv
// Load data formatter: turns four raw little-endian bytes into a 32-bit load value.
//   raw_i  : bytes mem[a+3..a] packed as {b3,b2,b1,b0}
//   size_i : SZ_BYTE / SZ_HALF / SZ_WORD
//   sign_i : 1 = sign-extend sub-word loads, 0 = zero-extend
//   data_o : extended load value
module mc_load_align
  import mc_mem_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{sign_i & raw_i[7]}}, raw_i[7:0]};
      SZ_HALF: data_o = {{16{sign_i & raw_i[15]}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mc_datamem_ctrl.sv
// Byte-addressed little-endian data memory with a valid/ready request port and a
// fixed-latency response pulse.
//   clk, rst                : clock, asynchronous active-high reset
//   req_valid / req_ready   : request handshake (accept = valid & ready at a rising edge)
//   req_we, req_size        : store/load, byte/half/word
//   req_signed              : sign-extend sub-word loads
//   req_addr, req_wdata     : byte address, store data (low bits for sub-word)
//   rsp_valid               : one-cycle pulse LAT edges after acceptance
//   rsp_rdata, rsp_err      : load data (0 for stores/errors), error flag; held between pulses
module mc_datamem_ctrl
  import mc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = 3;  // holds LAT-1 for LAT up to 8

  logic [7:0] mem [0:Depth-1];

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ready_q;
  logic [31:0]       pend_rdata_q, rsp_rdata_q;
  logic              pend_err_q, rsp_err_q;

  logic              accept;
  logic              acc_err;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       raw;
  logic [31:0]       ld_data;
  logic [31:0]       new_rdata;
  logic [2:0]        nbytes;

  assign accept  = req_valid & ready_q;
  assign acc_err = access_err(req_size, req_addr, ADDR_W);
  assign idx     = req_addr[ADDR_W-1:0];

  // Indices wrap within the array; a wrapped byte only ever belongs to an errored access.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 4; i++) begin
      raw[8*i +: 8] = mem[idx + ADDR_W'(i)];
    end
  end

  mc_load_align u_load_align (
    .raw_i  (raw),
    .size_i (req_size),
    .sign_i (req_signed),
    .data_o (ld_data)
  );

  assign new_rdata = (acc_err || req_we) ? 32'd0 : ld_data;

  always_comb begin
    case (req_size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // Stores commit at the accepting edge; the array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < nbytes) begin
          mem[idx + ADDR_W'(i)] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (LAT <= 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CntW'(LAT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 1) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Registered so ready stays low during reset and rises the cycle after release.
      ready_q <= (state_d == ST_IDLE) || (state_d == ST_RESP);
      if (accept) begin
        pend_rdata_q <= new_rdata;
        pend_err_q   <= acc_err;
      end
      if (state_d == ST_RESP) begin
        // Entering RESP on an accept only happens with LAT==1: bypass the holding register.
        if (accept) begin
          rsp_rdata_q <= new_rdata;
          rsp_err_q   <= acc_err;
        end else begin
          rsp_rdata_q <= pend_rdata_q;
          rsp_err_q   <= pend_err_q;
        end
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mc_datamem_ctrl.sv
// Directed bench for mc_datamem_ctrl: three instances with LAT = 1, 3, 4 (ADDR_W = 6).
module tb_mc_datamem_ctrl;
  import mc_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [1:0]  req_size   [3];
  logic        req_signed [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  int n_chk = 0;
  int n_bad = 0;

  mc_datamem_ctrl #(.ADDR_W(6), .LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );
  mc_datamem_ctrl #(.ADDR_W(6), .LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );
  mc_datamem_ctrl #(.ADDR_W(6), .LAT(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_signed(req_signed[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated request on an idle instance; checks latency, data, error, pulse width, hold.
  task automatic xact(input int k, input string tag, input logic we, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    int waited;
    req_valid[k] = 1'b1; req_we[k] = we; req_size[k] = sz; req_signed[k] = sg;
    req_addr[k] = a; req_wdata[k] = wd;
    step();
    req_valid[k] = 1'b0;
    waited = 1;
    while (rsp_valid[k] !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, " latency"}, 32'(waited), 32'(lat_of(k)));
    chk({tag, " rdata"}, rsp_rdata[k], exp_d);
    chk({tag, " err"}, 32'(rsp_err[k]), 32'(exp_e));
    step();
    chk({tag, " pulse end"}, 32'(rsp_valid[k]), 32'd0);
    chk({tag, " rdata hold"}, rsp_rdata[k], exp_d);
  endtask

  logic [31:0] la   [4];
  logic [1:0]  lsz  [4];
  logic        lsg  [4];
  logic [31:0] lexp [4];
  int          acc_cyc [4];
  int          rsp_cyc [4];

  initial begin
    int  na, nr, cyc;
    logic acc, seen;

    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = SZ_WORD; req_signed[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0;
    end
    rst = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset ready[%0d]", k), 32'(req_ready[k]), 32'd0);
      chk($sformatf("reset rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
      chk($sformatf("reset rdata[%0d]", k), rsp_rdata[k], 32'd0);
      chk($sformatf("reset err[%0d]", k), 32'(rsp_err[k]), 32'd0);
    end
    rst = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post-reset ready[%0d]", k), 32'(req_ready[k]), 32'd1);
    end

    // 1. word store / load round trip
    xact(0, "sw 0x04", 1'b1, SZ_WORD, 1'b0, 32'h04, 32'hDEADBEEF, 32'h0, 1'b0);
    xact(0, "lw 0x04", 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("mem[4]", 32'(u_l1.mem[4]), 32'h000000EF);

    // 2. byte store and sign/zero extension
    xact(0, "sb 0x05", 1'b1, SZ_BYTE, 1'b0, 32'h05, 32'h12345680, 32'h0, 1'b0);
    xact(0, "lb 0x05", 1'b0, SZ_BYTE, 1'b1, 32'h05, 32'h0, 32'hFFFFFF80, 1'b0);
    xact(0, "lbu 0x05", 1'b0, SZ_BYTE, 1'b0, 32'h05, 32'h0, 32'h00000080, 1'b0);
    xact(0, "lw 0x04 b", 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, 32'hDEAD80EF, 1'b0);
    xact(0, "lh 0x04", 1'b0, SZ_HALF, 1'b1, 32'h04, 32'h0, 32'hFFFF80EF, 1'b0);

    // 3. error cases and top-of-memory boundary
    xact(0, "lh 0x03 misal", 1'b0, SZ_HALF, 1'b1, 32'h03, 32'h0, 32'h0, 1'b1);
    xact(0, "sw 0x00", 1'b1, SZ_WORD, 1'b0, 32'h00, 32'hA5A5A5A5, 32'h0, 1'b0);
    xact(0, "sw 0x40 range", 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11223344, 32'h0, 1'b1);
    xact(0, "lw 0x00 intact", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'hA5A5A5A5, 1'b0);
    xact(0, "size 11", 1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 32'h0, 1'b1);
    xact(0, "lw 0x3D misal", 1'b0, SZ_WORD, 1'b0, 32'h3D, 32'h0, 32'h0, 1'b1);
    xact(0, "sb 0x3F", 1'b1, SZ_BYTE, 1'b0, 32'h3F, 32'h0000007F, 32'h0, 1'b0);
    xact(0, "lb 0x3F", 1'b0, SZ_BYTE, 1'b1, 32'h3F, 32'h0, 32'h0000007F, 1'b0);

    // 4. LAT=3 back-to-back loads with req_valid held high
    xact(1, "l3 sw 0x10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h01020304, 32'h0, 1'b0);
    xact(1, "l3 sw 0x14", 1'b1, SZ_WORD, 1'b0, 32'h14, 32'h8899AABB, 32'h0, 1'b0);
    xact(1, "l3 sw 0x18", 1'b1, SZ_WORD, 1'b0, 32'h18, 32'hCAFEF00D, 32'h0, 1'b0);
    xact(1, "l3 sw 0x1C", 1'b1, SZ_WORD, 1'b0, 32'h1C, 32'h7E7F8081, 32'h0, 1'b0);
    la[0] = 32'h10; lsz[0] = SZ_WORD; lsg[0] = 1'b0; lexp[0] = 32'h01020304;
    la[1] = 32'h17; lsz[1] = SZ_BYTE; lsg[1] = 1'b1; lexp[1] = 32'hFFFFFF88;
    la[2] = 32'h1A; lsz[2] = SZ_HALF; lsg[2] = 1'b0; lexp[2] = 32'h0000CAFE;
    la[3] = 32'h1C; lsz[3] = SZ_HALF; lsg[3] = 1'b1; lexp[3] = 32'hFFFF8081;
    for (int i = 0; i < 4; i++) begin
      acc_cyc[i] = -1;
      rsp_cyc[i] = -1;
    end
    na = 0; nr = 0; cyc = 0;
    req_valid[1] = 1'b1; req_we[1] = 1'b0;
    req_addr[1] = la[0]; req_size[1] = lsz[0]; req_signed[1] = lsg[0];
    while (nr < 4 && cyc < 40) begin
      acc = req_valid[1] & req_ready[1];
      step();
      cyc++;
      if (acc) begin
        acc_cyc[na] = cyc;
        na++;
        if (na < 4) begin
          req_addr[1] = la[na]; req_size[1] = lsz[na]; req_signed[1] = lsg[na];
        end else begin
          req_valid[1] = 1'b0;
        end
      end
      if (rsp_valid[1] === 1'b1 && nr < 4) begin
        rsp_cyc[nr] = cyc;
        chk($sformatf("b2b rdata %0d", nr), rsp_rdata[1], lexp[nr]);
        chk($sformatf("b2b err %0d", nr), 32'(rsp_err[1]), 32'd0);
        nr++;
      end
      if (cyc <= 12) begin
        chk($sformatf("b2b ready cyc %0d", cyc), 32'(req_ready[1]), 32'((cyc % 3) == 0));
      end
    end
    chk("b2b responses", 32'(nr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b accept %0d", i), 32'(acc_cyc[i]), 32'(1 + 3 * i));
      chk($sformatf("b2b rsp delay %0d", i), 32'(rsp_cyc[i] - acc_cyc[i] + 1), 32'd3);
    end
    step();

    // 5. LAT=4, reset while a load is pending
    xact(2, "l4 sw 0x20", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0BADF00D, 32'h0, 1'b0);
    seen = 1'b0;
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_size[2] = SZ_WORD; req_addr[2] = 32'h20;
    step();
    req_valid[2] = 1'b0;
    seen |= rsp_valid[2];
    step();
    seen |= rsp_valid[2];
    step();
    seen |= rsp_valid[2];
    rst = 1'b1;
    #1;
    chk("mid-rst ready", 32'(req_ready[2]), 32'd0);
    chk("mid-rst rdata", rsp_rdata[2], 32'd0);
    chk("mid-rst err", 32'(rsp_err[2]), 32'd0);
    repeat (2) begin
      step();
      seen |= rsp_valid[2];
    end
    rst = 1'b0;
    step();
    chk("post-rst ready", 32'(req_ready[2]), 32'd1);
    repeat (6) begin
      seen |= rsp_valid[2];
      step();
    end
    chk("dropped rsp_valid", 32'(seen), 32'd0);
    xact(2, "l4 lw 0x20", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);

    // 6. half store inside a word previously written (memory survived reset)
    xact(0, "sh 0x02", 1'b1, SZ_HALF, 1'b0, 32'h02, 32'hFFFF1234, 32'h0, 1'b0);
    xact(0, "lw 0x00 sh", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'h1234A5A5, 1'b0);
    chk("mem[2]", 32'(u_l1.mem[2]), 32'h00000034);
    chk("mem[3]", 32'(u_l1.mem[3]), 32'h00000012);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
